// File: rtl/instr_mem_responder_if.sv
// Fetch and preload bus between an instruction front end and its memory responder.
interface instr_mem_responder_if;
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic [31:0] instr_mem_rdata;
    logic        instr_mem_resp;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        read_error;
    logic        busy;

    modport slave (
        input  instr_read, instr_mem_address, load_we, load_addr, load_data,
        output instr_mem_rdata, instr_mem_resp, read_error, busy
    );

    modport master (
        output instr_read, instr_mem_address, load_we, load_addr, load_data,
        input  instr_mem_rdata, instr_mem_resp, read_error, busy
    );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: one word per fetch after a programmable latency.
// Optional IMEM_STALL_INJECT_EN adds 0..3 LFSR-chosen extra stall cycles per fetch.
module instr_mem_responder #(
    parameter int          LATENCY     = 2,
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0060
) (
    input logic                  clk,
    input logic                  rst,
    instr_mem_responder_if.slave bus
);
    localparam int          IW  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_STALL_INJECT_EN
    localparam int CW = 5;
`else
    localparam int CW = 4;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] lat_m1;
    logic [31:0]   fetch_addr;
    logic [31:0]   mem [DEPTH_WORDS];

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE_ADDR) &&
               ((a - BASE_ADDR) < 32'(DEPTH_WORDS * 4));
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [31:0] a);
        return IW'((a - BASE_ADDR) >> 2);
    endfunction

`ifdef IMEM_STALL_INJECT_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 8'hA5;
        else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign lat_m1 = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);
`else
    assign lat_m1 = CW'(LATENCY - 1);
`endif

    // With a one-cycle latency the capture happens on the accepting edge, before addr_q is loaded.
    assign fetch_addr = (state_q == IDLE) ? bus.instr_mem_address : addr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = '0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.instr_read) begin
                    addr_d  = bus.instr_mem_address;
                    cnt_d   = lat_m1;
                    state_d = (lat_m1 == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (!bus.instr_read || (bus.instr_mem_address != addr_q)) err_d = 1'b1;
                if (cnt_d == '0) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == RESP && state_q != RESP) begin
            if (addr_ok(fetch_addr)) begin
                rdata_d = mem[addr_idx(fetch_addr)];
            end else begin
                rdata_d = NOP;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset so a loaded program outlives a core reset.
    always_ff @(posedge clk) begin
        if (bus.load_we && addr_ok(bus.load_addr)) mem[addr_idx(bus.load_addr)] <= bus.load_data;
    end

    assign bus.instr_mem_rdata = rdata_q;
    assign bus.instr_mem_resp  = (state_q == RESP);
    assign bus.read_error      = err_q;
    assign bus.busy            = (state_q != IDLE);
endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: directed table, multi-cycle corner sequences, random vs model.
module tb_instr_mem_responder;
    localparam logic [31:0] BASE  = 32'h0000_0060;
    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_STALL_INJECT_EN
    localparam int XTRA = 3;
`else
    localparam int XTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst2, rst4;
    always #5 clk = ~clk;

    instr_mem_responder_if b2 ();
    instr_mem_responder_if b4 ();

    instr_mem_responder #(.LATENCY(2), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) u_d2 (
        .clk(clk), .rst(rst2), .bus(b2.slave));
    instr_mem_responder #(.LATENCY(4), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) u_d4 (
        .clk(clk), .rst(rst4), .bus(b4.slave));

    int errs = 0;
    int checks = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          pre;
        logic        err;
        bit          hold;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_lat(input string nm, input int lat, input int lo, input int hi);
        checks++;
        if (lat < lo || lat > hi) begin
            errs++;
            $display("FAIL %s: latency %0d expected %0d..%0d", nm, lat, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit valid_a(input logic [31:0] a);
        return (a % 4 == 0) && (a >= BASE) && (longint'(a) < longint'(BASE) + DEPTH * 4);
    endfunction

    function automatic logic [31:0] expect_word(input logic [31:0] a);
        if (!valid_a(a)) return NOP;
        return model_mem[(a - BASE) / 4];
    endfunction

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 7)  return BASE + 4 * $urandom_range(0, DEPTH - 1);
        if (k == 7) return BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
        if (k == 8) return $urandom_range(0, BASE - 1);
        return BASE + DEPTH * 4 + $urandom_range(0, 400);
    endfunction

    task automatic load2(input logic [31:0] a, input logic [31:0] d);
        b2.load_we = 1'b1; b2.load_addr = a; b2.load_data = d;
        tick();
        b2.load_we = 1'b0;
        if (valid_a(a)) model_mem[(a - BASE) / 4] = d;
    endtask

    // pre = number of IDLE cycles expected before the request is accepted (1 when chained from RESP).
    task automatic fetch2(input logic [31:0] a, input int pre, output int lat,
                          output logic [31:0] data, output bit side_ok);
        b2.instr_read = 1'b1; b2.instr_mem_address = a;
        lat = 0; side_ok = 1'b1; data = '0;
        while (lat < 40) begin
            tick();
            lat++;
            if (b2.busy !== (lat > pre)) side_ok = 1'b0;
            if (b2.instr_mem_resp === 1'b1) break;
            if (b2.instr_mem_rdata !== 32'h0) side_ok = 1'b0;
        end
        data = b2.instr_mem_rdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        int          lat;
        logic [31:0] data;
        bit          ok;
        logic [3:0]  seen;

        tbl[0] = '{32'h0000_0060, 32'h0050_0093, 0, 1'b0, 1'b1};
        tbl[1] = '{32'h0000_0064, 32'h0010_8113, 1, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_045C, 32'hCAFE_F00D, 0, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_0062, NOP,           0, 1'b1, 1'b0};
        tbl[4] = '{32'h0000_0460, NOP,           0, 1'b1, 1'b0};
        tbl[5] = '{32'h0000_005C, NOP,           0, 1'b1, 1'b0};

        b2.instr_read = 1'b0; b2.instr_mem_address = '0;
        b2.load_we = 1'b0; b2.load_addr = '0; b2.load_data = '0;
        b4.instr_read = 1'b0; b4.instr_mem_address = '0;
        b4.load_we = 1'b0; b4.load_addr = '0; b4.load_data = '0;
        model_err = 1'b0;
        seen = '0;
        rst2 = 1'b1; rst4 = 1'b1;
        repeat (3) tick();
        rst2 = 1'b0; rst4 = 1'b0;
        chk("reset_resp",  {31'b0, b2.instr_mem_resp}, 32'h0);
        chk("reset_rdata", b2.instr_mem_rdata, 32'h0);
        chk("reset_err",   {31'b0, b2.read_error}, 32'h0);
        chk("reset_busy",  {31'b0, b2.busy}, 32'h0);
        chk("reset4_busy", {31'b0, b4.busy}, 32'h0);

        // Directed table; the misaligned preload at 0x61 must not disturb word 0.
        load2(32'h60, 32'h0050_0093);
        load2(32'h64, 32'h0010_8113);
        load2(32'h45C, 32'hCAFE_F00D);
        load2(32'h61, 32'hDEAD_BEEF);
        for (int i = 0; i < 6; i++) begin
            fetch2(tbl[i].addr, tbl[i].pre, lat, data, ok);
            chk_lat($sformatf("tbl%0d_lat", i), lat, 2 + tbl[i].pre, 2 + tbl[i].pre + XTRA);
            chk($sformatf("tbl%0d_data", i), data, tbl[i].data);
            chk($sformatf("tbl%0d_err", i), {31'b0, b2.read_error}, {31'b0, tbl[i].err});
            chk($sformatf("tbl%0d_busy_rdata", i), {31'b0, ok}, 32'h1);
            if (!tbl[i].hold) begin
                b2.instr_read = 1'b0;
                tick();
            end
        end

        // Reset clears the sticky error but leaves the array intact.
        rst2 = 1'b1; tick(); rst2 = 1'b0;
        chk("rst_clears_err", {31'b0, b2.read_error}, 32'h0);
        fetch2(32'h60, 0, lat, data, ok);
        chk("array_kept_data", data, 32'h0050_0093);
        b2.instr_read = 1'b0; tick();

`ifndef IMEM_STALL_INJECT_EN
        // A write on the capture edge must not be seen by that response.
        load2(32'h68, 32'h1111_1111);
        b2.instr_read = 1'b1; b2.instr_mem_address = 32'h68;
        tick();
        b2.load_we = 1'b1; b2.load_addr = 32'h68; b2.load_data = 32'h2222_2222;
        tick();
        b2.load_we = 1'b0;
        model_mem[2] = 32'h2222_2222;
        chk("same_edge_resp", {31'b0, b2.instr_mem_resp}, 32'h1);
        chk("same_edge_old",  b2.instr_mem_rdata, 32'h1111_1111);
        b2.instr_read = 1'b0; tick();
        fetch2(32'h68, 0, lat, data, ok);
        chk("same_edge_new", data, 32'h2222_2222);
        b2.instr_read = 1'b0; tick();
`endif

        // Random traffic against the model.
        for (int i = 0; i < DEPTH; i++) load2(BASE + 4 * i, $urandom);
        for (int n = 0; n < 120; n++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 19);
            if (r < 5) begin
                a = rand_addr();
                load2(a, $urandom);
            end else if (r == 5) begin
                rst2 = 1'b1; tick(); rst2 = 1'b0;
                model_err = 1'b0;
            end else begin
                a = rand_addr();
                fetch2(a, 0, lat, data, ok);
                if (!valid_a(a)) model_err = 1'b1;
                chk_lat("rnd_lat", lat, 2, 2 + XTRA);
                chk("rnd_data", data, expect_word(a));
                chk("rnd_err", {31'b0, b2.read_error}, {31'b0, model_err});
                if (lat >= 2 && lat <= 5) seen[lat - 2] = 1'b1;
                b2.instr_read = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
`ifdef IMEM_STALL_INJECT_EN
        chk("stall_values_seen", {28'b0, seen}, 32'hF);
`endif

        // LATENCY=4 device: address change mid-wait.
        b4.load_we = 1'b1; b4.load_addr = 32'h60; b4.load_data = 32'hAAAA_0001; tick();
        b4.load_addr = 32'h64; b4.load_data = 32'hBBBB_0002; tick();
        b4.load_we = 1'b0;
        b4.instr_read = 1'b1; b4.instr_mem_address = 32'h60;
        tick(); tick();
        b4.instr_mem_address = 32'h64;
        lat = 2;
        while (lat < 40 && b4.instr_mem_resp !== 1'b1) begin tick(); lat++; end
        chk_lat("proto_lat", lat, 4, 4 + XTRA);
        chk("proto_data", b4.instr_mem_rdata, 32'hAAAA_0001);
        chk("proto_err",  {31'b0, b4.read_error}, 32'h1);
        b4.instr_read = 1'b0; tick();

        // Reset in WAIT aborts; a request right after reset is accepted.
        rst4 = 1'b1; tick(); rst4 = 1'b0; tick();
        b4.instr_read = 1'b1; b4.instr_mem_address = 32'h60;
        tick();
        rst4 = 1'b1; b4.instr_read = 1'b0;
        tick();
        chk("abort_resp",  {31'b0, b4.instr_mem_resp}, 32'h0);
        chk("abort_rdata", b4.instr_mem_rdata, 32'h0);
        chk("abort_busy",  {31'b0, b4.busy}, 32'h0);
        rst4 = 1'b0;
        b4.instr_read = 1'b1; b4.instr_mem_address = 32'h64;
        lat = 0;
        while (lat < 40) begin
            tick(); lat++;
            if (b4.instr_mem_resp === 1'b1) break;
        end
        chk_lat("after_rst_lat", lat, 4, 4 + XTRA);
        chk("after_rst_data", b4.instr_mem_rdata, 32'hBBBB_0002);
        chk("after_rst_err",  {31'b0, b4.read_error}, 32'h0);
        b4.instr_read = 1'b0; tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Synthesizable instruction-side memory responder that services the fetch handshake (`instr_read` / `instr_mem_address` -> `instr_mem_resp` / read data) issued by the instruction register/queue front end. It holds a word-addressed instruction array that the bench or a loader preloads through a write port. It returns one word per request after a programmable latency and flags protocol and address errors. It replaces the behavioural magic memory in instruction-queue unit tests and in the top-level fetch path.

## Interface
- `LATENCY`, 2, cycles from request to response; legal range 1..15
- `DEPTH_WORDS`, 256, instruction array depth in 32-bit words; power of two
- `BASE_ADDR`, 32'h0000_0060, byte address of array word 0
- `clk` in 1: single clock; all logic is on the rising edge
- `rst` in 1: synchronous, active-high reset
- `instr_read` in 1: fetch request; held high until `instr_mem_resp`
- `instr_mem_address` in 32: byte address of the fetch; held stable while `instr_read` is high
- `instr_mem_rdata` out 32: fetched word; valid only while `instr_mem_resp`=1, otherwise 0
- `instr_mem_resp` out 1: one-cycle response pulse
- `load_we` in 1: preload write enable
- `load_addr` in 32: preload byte address, same mapping as fetch
- `load_data` in 32: preload word
- `read_error` out 1: sticky error flag, cleared only by `rst`
- `busy` out 1: high in WAIT and RESP

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `instr_read`=1 at the edge, latch the address and load the counter with the effective latency minus 1.
  - Go to RESP if the counter is 0, otherwise go to WAIT.
- WAIT:
  - Decrement the counter each edge; go to RESP when it reaches 0.
  - At the edge entering RESP, register the data into `instr_mem_rdata`.
- RESP:
  - `instr_mem_resp`=1 for exactly this cycle; always return to IDLE.
  - The edge ending RESP is not a request sampling point. A requester that still holds `instr_read` high in the following IDLE cycle starts a new transaction.
- Address mapping: `off = addr - BASE_ADDR`; word index = `off[2+:log2(DEPTH_WORDS)]`.
- Invalid fetch addresses:
  - Misaligned (`addr[1:0]`!=0) or out of range (`addr < BASE_ADDR` or `off >= DEPTH_WORDS*4`).
  - The response is still delivered with normal timing. `rdata` = 32'h0000_0013 (NOP) and `read_error` is set.
- Protocol errors:
  - `instr_read` dropping, or `instr_mem_address` changing, while in WAIT sets `read_error`.
  - The transaction still completes using the latched address.
- Preload:
  - A `load_we` write with a valid aligned address writes the array in any state.
  - An invalid preload address is ignored; it does not set `read_error`.
- A write on the same edge that captures `rdata` is not visible in that response; old data is returned.
- The array is not cleared by `rst`.

## Timing
- Reset values: state IDLE, `instr_mem_resp`=0, `instr_mem_rdata`=0, `read_error`=0, `busy`=0, counter 0.
- Request first high in IDLE cycle c -> `instr_mem_resp` high in cycle c+L, where L is the effective latency.
- Back-to-back request period is L+1 cycles.
- `rst` in WAIT or RESP:
  - Aborts the transaction; no response is ever issued for it.
  - All outputs take their reset values on the next cycle.
  - A request is accepted in the first cycle after `rst` deasserts.
- Counter is 4 bits wide (5 bits with stall injection); no wrap is possible within the legal range.

## Configuration
- `IMEM_STALL_INJECT_EN` defined:
  - Adds an 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) that advances every cycle.
  - On request acceptance, L = `LATENCY` + `lfsr[1:0]` (extra 0..3 cycles).
- Not defined: no LFSR is present and L = `LATENCY` exactly.

## Test plan
- LATENCY=2; preload 0x60 <- 0x0050_0093; `instr_read` high with 0x60 in cycle 0 -> `instr_mem_resp`=1 only in cycle 2, `rdata`=0x0050_0093, `read_error`=0.
- Preload 0x64 <- 0x0010_8113; hold `instr_read` high, address 0x60 then 0x64 after the first resp -> resps in cycles 2 and 5 with correct words, `busy` low only in cycle 3.
- Fetch 0x62, then fetch 0x60+4*`DEPTH_WORDS` -> both resps on time with `rdata`=0x0000_0013; `read_error` rises after the first and stays 1.
- LATENCY=4; change the address from 0x60 to 0x64 in cycle 2 -> resp in cycle 4 with the word at 0x60, `read_error`=1.
- Assert `rst` in cycle 1 of a LATENCY=3 fetch -> no resp ever for it, outputs 0; a new fetch started right after `rst` deasserts responds 3 cycles later.
- With `IMEM_STALL_INJECT_EN`: 50 sequential fetches -> every response latency lies in 2..5, data always correct, all four extra-stall values observed.
